// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states and grant-owner encoding.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_CMD  = 2'd1,
      RD_DATA = 2'd2,
      WR_CMD  = 2'd3
   } state_t;

   typedef enum logic {
      GRANT_STIM  = 1'b0,
      GRANT_CHECK = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Two-input grant decision for the memory arbiter.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester not granted last; otherwise stim always wins.
module mem_arb_grant
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic   clock,
   input  logic   reset,
   input  logic   i_accept,
   input  grant_t i_acceptOwner,
`endif
   input  logic   i_reqStim,
   input  logic   i_reqCheck,
   output grant_t o_grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   grant_t r_lastGrant;

   // Starting at GRANT_CHECK makes the first tie after reset go to stim.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_lastGrant <= GRANT_CHECK;
      end else if (i_accept) begin
         r_lastGrant <= i_acceptOwner;
      end
   end

   always_comb begin
      o_grant = GRANT_STIM;
      if (i_reqStim && i_reqCheck) begin
         o_grant = (r_lastGrant == GRANT_STIM) ? GRANT_CHECK : GRANT_STIM;
      end else if (i_reqCheck) begin
         o_grant = GRANT_CHECK;
      end
   end
`else
   always_comb begin
      o_grant = GRANT_STIM;
      if (i_reqCheck && !i_reqStim) begin
         o_grant = GRANT_CHECK;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between a read-only and a write-only requester, with read-data timeout.
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin ties instead of fixed stim priority).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 16,
   parameter int BE_WIDTH   = DATA_WIDTH / 8,
   parameter int TO_WIDTH   = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] stim_address,
   input  logic [BE_WIDTH-1:0]   stim_byteenable,
   input  logic                  stim_read,
   output logic                  stim_waitrequest,
   output logic [DATA_WIDTH-1:0] stim_readdata,
   output logic                  stim_readdataready,
   input  logic [ADDR_WIDTH-1:0] check_address,
   input  logic [BE_WIDTH-1:0]   check_byteenable,
   input  logic [DATA_WIDTH-1:0] check_writedata,
   input  logic                  check_write,
   output logic                  check_waitrequest,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [BE_WIDTH-1:0]   mem_byteenable,
   output logic [DATA_WIDTH-1:0] mem_writedata,
   output logic                  mem_read,
   output logic                  mem_write,
   input  logic [DATA_WIDTH-1:0] mem_readdata,
   input  logic                  mem_readdataready,
   input  logic                  mem_waitrequest,
   output logic                  rd_timeout,
   input  logic                  rd_timeout_clr
);

   localparam logic [TO_WIDTH-1:0] TO_MAX = '1;

   state_t              r_state;
   state_t              w_nextState;
   logic [TO_WIDTH-1:0] r_toCount;
   logic                r_rdTimeout;
   logic                w_timeout;
   grant_t              w_grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic   w_accept;
   grant_t w_acceptOwner;

   assign w_accept = !mem_waitrequest &&
                     (((r_state == RD_CMD) && stim_read) || ((r_state == WR_CMD) && check_write));
   assign w_acceptOwner = (r_state == WR_CMD) ? GRANT_CHECK : GRANT_STIM;
`endif

   mem_arb_grant u_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .clock         (clock),
      .reset         (reset),
      .i_accept      (w_accept),
      .i_acceptOwner (w_acceptOwner),
`endif
      .i_reqStim     (stim_read),
      .i_reqCheck    (check_write),
      .o_grant       (w_grant)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Counter is held at zero while the read command is pending, so it starts at 0 on acceptance.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_toCount <= '0;
      end else if (r_state == RD_DATA) begin
         r_toCount <= r_toCount + 1'b1;
      end else begin
         r_toCount <= '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rdTimeout <= 1'b0;
      end else if (w_timeout) begin
         r_rdTimeout <= 1'b1;
      end else if (rd_timeout_clr) begin
         r_rdTimeout <= 1'b0;
      end
   end

   assign rd_timeout = r_rdTimeout;

   // Command strobes follow the live request so a withdrawn request never reaches memory.
   always_comb begin
      w_nextState        = r_state;
      w_timeout          = 1'b0;
      stim_waitrequest   = 1'b1;
      check_waitrequest  = 1'b1;
      stim_readdata      = '0;
      stim_readdataready = 1'b0;
      mem_address        = '0;
      mem_byteenable     = '0;
      mem_writedata      = '0;
      mem_read           = 1'b0;
      mem_write          = 1'b0;
      case (r_state)
         IDLE: begin
            if (stim_read || check_write) begin
               w_nextState = (w_grant == GRANT_STIM) ? RD_CMD : WR_CMD;
            end
         end
         RD_CMD: begin
            mem_address      = stim_address;
            mem_byteenable   = stim_byteenable;
            mem_read         = stim_read;
            stim_waitrequest = mem_waitrequest;
            if (!stim_read) begin
               w_nextState = IDLE;
            end else if (!mem_waitrequest) begin
               w_nextState = RD_DATA;
            end
         end
         RD_DATA: begin
            if (mem_readdataready) begin
               stim_readdataready = 1'b1;
               stim_readdata      = mem_readdata;
               w_nextState        = IDLE;
            end else if (r_toCount == TO_MAX) begin
               stim_readdataready = 1'b1;
               w_timeout          = 1'b1;
               w_nextState        = IDLE;
            end
         end
         WR_CMD: begin
            mem_address       = check_address;
            mem_byteenable    = check_byteenable;
            mem_writedata     = check_writedata;
            mem_write         = check_write;
            check_waitrequest = mem_waitrequest;
            if (!check_write || !mem_waitrequest) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TO_WIDTH=4); follows MEM_ARB_ROUND_ROBIN_EN for tie order.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [19:0] stim_address;
   logic [1:0]  stim_byteenable;
   logic        stim_read;
   logic        stim_waitrequest;
   logic [15:0] stim_readdata;
   logic        stim_readdataready;
   logic [19:0] check_address;
   logic [1:0]  check_byteenable;
   logic [15:0] check_writedata;
   logic        check_write;
   logic        check_waitrequest;
   logic [19:0] mem_address;
   logic [1:0]  mem_byteenable;
   logic [15:0] mem_writedata;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_readdata;
   logic        mem_readdataready;
   logic        mem_waitrequest;
   logic        rd_timeout;
   logic        rd_timeout_clr;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   mem_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .BE_WIDTH(2), .TO_WIDTH(4)) dut (
      .clock              (clock),
      .reset              (reset),
      .stim_address       (stim_address),
      .stim_byteenable    (stim_byteenable),
      .stim_read          (stim_read),
      .stim_waitrequest   (stim_waitrequest),
      .stim_readdata      (stim_readdata),
      .stim_readdataready (stim_readdataready),
      .check_address      (check_address),
      .check_byteenable   (check_byteenable),
      .check_writedata    (check_writedata),
      .check_write        (check_write),
      .check_waitrequest  (check_waitrequest),
      .mem_address        (mem_address),
      .mem_byteenable     (mem_byteenable),
      .mem_writedata      (mem_writedata),
      .mem_read           (mem_read),
      .mem_write          (mem_write),
      .mem_readdata       (mem_readdata),
      .mem_readdataready  (mem_readdataready),
      .mem_waitrequest    (mem_waitrequest),
      .rd_timeout         (rd_timeout),
      .rd_timeout_clr     (rd_timeout_clr)
   );

   task automatic quietInputs();
      stim_address      = '0;
      stim_byteenable   = '0;
      stim_read         = 1'b0;
      check_address     = '0;
      check_byteenable  = '0;
      check_writedata   = '0;
      check_write       = 1'b0;
      mem_readdata      = '0;
      mem_readdataready = 1'b0;
      mem_waitrequest   = 1'b0;
      rd_timeout_clr    = 1'b0;
   endtask

   task automatic test_reset();
      quietInputs();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      total++; if (stim_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL reset_stim_wr got=%b exp=1", stim_waitrequest); end
      total++; if (check_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL reset_check_wr got=%b exp=1", check_waitrequest); end
      total++; if ({mem_read, mem_write, stim_readdataready, rd_timeout} !== 4'b0) begin bad++; $display("[TB] FAIL reset_strobes got=%b exp=0000", {mem_read, mem_write, stim_readdataready, rd_timeout}); end
      total++; if ({mem_address, mem_byteenable, mem_writedata, stim_readdata} !== 54'h0) begin bad++; $display("[TB] FAIL reset_fields got=%h exp=0", {mem_address, mem_byteenable, mem_writedata, stim_readdata}); end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      @(negedge clock);
      stim_read = 1'b1; stim_address = 20'h00010; stim_byteenable = 2'b11;
      #1;
      total++; if (mem_read !== 1'b0 || stim_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rd_idle got=%b%b exp=01", mem_read, stim_waitrequest); end
      @(negedge clock); #1;
      total++; if (mem_read !== 1'b1) begin bad++; $display("[TB] FAIL rd_cmd_read got=%b exp=1", mem_read); end
      total++; if (mem_address !== 20'h00010 || mem_byteenable !== 2'b11) begin bad++; $display("[TB] FAIL rd_cmd_fields got=%h/%b exp=00010/11", mem_address, mem_byteenable); end
      total++; if (stim_waitrequest !== 1'b0 || check_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rd_cmd_wr got=%b%b exp=01", stim_waitrequest, check_waitrequest); end
      @(negedge clock);
      stim_read = 1'b0;
      #1;
      total++; if (mem_read !== 1'b0 || stim_readdataready !== 1'b0 || mem_address !== 20'h0) begin bad++; $display("[TB] FAIL rd_wait got=%b%b/%h exp=00/0", mem_read, stim_readdataready, mem_address); end
      @(negedge clock);
      mem_readdataready = 1'b1; mem_readdata = 16'hBEEF;
      #1;
      total++; if (stim_readdataready !== 1'b1 || stim_readdata !== 16'hBEEF) begin bad++; $display("[TB] FAIL rd_data got=%b/%h exp=1/beef", stim_readdataready, stim_readdata); end
      total++; if (check_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rd_data_cwr got=%b exp=1", check_waitrequest); end
      @(negedge clock);
      #1;
      total++; if (stim_readdataready !== 1'b0 || stim_readdata !== 16'h0) begin bad++; $display("[TB] FAIL rd_stray_ready got=%b/%h exp=0/0", stim_readdataready, stim_readdata); end
      @(negedge clock);
      mem_readdataready = 1'b0; mem_readdata = '0;
   endtask

   task automatic test_write_stall();
      @(negedge clock);
      check_write = 1'b1; check_address = 20'h00020; check_writedata = 16'h1234;
      check_byteenable = 2'b01; mem_waitrequest = 1'b1;
      #1;
      total++; if (mem_write !== 1'b0) begin bad++; $display("[TB] FAIL wr_idle got=%b exp=0", mem_write); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         mem_waitrequest = (i < 3);
         #1;
         total++; if (mem_write !== 1'b1 || mem_address !== 20'h00020 || mem_writedata !== 16'h1234 || mem_byteenable !== 2'b01) begin
            bad++; $display("[TB] FAIL wr_cmd_%0d got=%b/%h/%h/%b exp=1/00020/1234/01", i, mem_write, mem_address, mem_writedata, mem_byteenable);
         end
         total++; if (check_waitrequest !== (i < 3) || stim_waitrequest !== 1'b1) begin
            bad++; $display("[TB] FAIL wr_wait_%0d got=%b%b exp=%b1", i, check_waitrequest, stim_waitrequest, (i < 3));
         end
      end
      @(negedge clock);
      check_write = 1'b0;
      #1;
      total++; if (mem_write !== 1'b0 || mem_address !== 20'h0 || check_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL wr_done got=%b/%h/%b exp=0/0/1", mem_write, mem_address, check_waitrequest); end
      quietInputs();
   endtask

   task automatic test_back_to_back();
      logic seqStim [8];
      int   nStim = 0;
      int   nCheck = 0;
      int   n = 0;
      logic pending = 1'b0;
      bit   expStim;
      for (int cyc = 0; cyc < 100 && n < 8; cyc++) begin
         @(negedge clock);
         mem_readdataready = pending;
         mem_readdata      = 16'hA000 + 16'(n);
         pending           = 1'b0;
         stim_read         = (nStim < 4);
         check_write       = (nCheck < 4);
         stim_address      = 20'h00100 + 20'(nStim);
         check_address     = 20'h00200 + 20'(nCheck);
         mem_waitrequest   = 1'b0;
         #1;
         if (mem_read) begin
            seqStim[n] = 1'b1; n++; nStim++; pending = 1'b1;
         end else if (mem_write) begin
            seqStim[n] = 1'b0; n++; nCheck++;
         end
      end
      total++; if (n !== 8) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=8", n); end
      for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         expStim = (i % 2 == 0);
`else
         expStim = (i < 4);
`endif
         total++; if (seqStim[i] !== expStim) begin bad++; $display("[TB] FAIL b2b_order_%0d got=%b exp=%b", i, seqStim[i], expStim); end
      end
      @(negedge clock);
      quietInputs();
      repeat (2) @(negedge clock);
   endtask

   task automatic test_timeout(input logic holdClear);
      @(negedge clock);
      stim_read = 1'b1; stim_address = 20'h00030; rd_timeout_clr = holdClear;
      @(negedge clock); #1;
      total++; if (mem_read !== 1'b1) begin bad++; $display("[TB] FAIL to_cmd got=%b exp=1", mem_read); end
      @(negedge clock);
      stim_read = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         if (i > 1) @(negedge clock);
         #1;
         total++; if (stim_readdataready !== (i == 16) || stim_readdata !== 16'h0 || rd_timeout !== 1'b0) begin
            bad++; $display("[TB] FAIL to_cycle_%0d got=%b/%h/%b exp=%b/0000/0", i, stim_readdataready, stim_readdata, rd_timeout, (i == 16));
         end
      end
      @(negedge clock); #1;
      total++; if (rd_timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_flag_set clr=%b got=%b exp=1", holdClear, rd_timeout); end
      total++; if (stim_readdataready !== 1'b0) begin bad++; $display("[TB] FAIL to_after got=%b exp=0", stim_readdataready); end
      rd_timeout_clr = 1'b1;
      @(negedge clock);
      rd_timeout_clr = 1'b0;
      #1;
      total++; if (rd_timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_flag_clr got=%b exp=0", rd_timeout); end
   endtask

   task automatic test_abort();
      @(negedge clock);
      stim_read = 1'b1; stim_address = 20'h00040; mem_waitrequest = 1'b1;
      @(negedge clock); #1;
      total++; if (mem_read !== 1'b1 || stim_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL abort_stall got=%b%b exp=11", mem_read, stim_waitrequest); end
      @(negedge clock);
      stim_read = 1'b0;
      @(negedge clock);
      mem_waitrequest = 1'b0; mem_readdataready = 1'b1; mem_readdata = 16'hBEEF;
      #1;
      total++; if (stim_readdataready !== 1'b0 || mem_read !== 1'b0 || stim_readdata !== 16'h0) begin bad++; $display("[TB] FAIL abort_idle got=%b%b/%h exp=00/0000", stim_readdataready, mem_read, stim_readdata); end
      @(negedge clock);
      mem_readdataready = 1'b0;
      #1;
      total++; if (stim_waitrequest !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("[TB] FAIL abort_stay got=%b%b exp=10", stim_waitrequest, mem_read); end
      quietInputs();
   endtask

   task automatic test_reset_mid_read();
      @(negedge clock);
      stim_read = 1'b1; stim_address = 20'h00050; stim_byteenable = 2'b10;
      @(negedge clock);
      stim_read = 1'b0;
      @(negedge clock);
      mem_readdataready = 1'b1; mem_readdata = 16'hBEEF; reset = 1'b1;
      #1;
      total++; if (stim_readdataready !== 1'b0 || stim_readdata !== 16'h0) begin bad++; $display("[TB] FAIL rst_mid_data got=%b/%h exp=0/0000", stim_readdataready, stim_readdata); end
      total++; if (stim_waitrequest !== 1'b1 || check_waitrequest !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
         bad++; $display("[TB] FAIL rst_mid_ctl got=%b%b%b%b exp=1100", stim_waitrequest, check_waitrequest, mem_read, mem_write);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      total++; if (stim_readdataready !== 1'b0 || mem_address !== 20'h0) begin bad++; $display("[TB] FAIL rst_mid_after got=%b/%h exp=0/0", stim_readdataready, mem_address); end
      quietInputs();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_stall();
      test_back_to_back();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_abort();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
